// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Shares one W-bit output channel among N requesters. A winner is chosen
//   either round-robin (search from ptr, wrapping N-1 -> 0) or by fixed
//   priority (lowest index). The winner's word and index are latched and
//   offered downstream with a valid/ready handshake. Back-to-back transfers
//   sustain one word per cycle. The just-served requester is masked out of the
//   re-arbitration that happens on its own transfer edge.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous reset, active-high
//   mode       in   1            0 = round-robin, 1 = fixed priority
//   req        in   N            per-requester request, held until ack
//   req_data   in   N x W        per-requester word
//   ack        out  N            one-hot pulse, the granted word was accepted
//   out_valid  out  1            out_data/out_src hold a granted word
//   out_ready  in   1            downstream ready
//   out_data   out  W            latched word of the granted requester
//   out_src    out  IW           index of the granted requester
//   busy_cnt   out  IW+1         popcount of req
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int N  = 32,
  parameter int W  = 20,
  parameter int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [N-1:0]        req,
  input  logic [N-1:0][W-1:0] req_data,
  output logic [N-1:0]        ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [IW-1:0]       out_src,
  output logic [IW:0]         busy_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Winner search. Returns {found, index}. In round-robin mode the search
  // starts at 'start' and wraps. In fixed mode it starts at index 0.
  // Iterating downward leaves the smallest offset as the final assignment.
  function automatic logic [IW:0] pick(input logic [N-1:0]  elig,
                                       input logic [IW-1:0] start,
                                       input logic          fixed);
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    idx = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      cand = fixed ? IW'(i) : (start + IW'(i));
      idx  = elig[cand] ? cand : idx;
    end
    return {|elig, idx};
  endfunction

  // Population count of the request vector.
  function automatic logic [IW:0] popcount(input logic [N-1:0] v);
    logic [IW:0] cnt;
    cnt = {(IW+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{IW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] src_q, src_d;

  logic          fire_s;
  logic          arb_en_s;
  logic [N-1:0]  ack_s;
  logic [N-1:0]  elig_s;
  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic          grant_s;

  // Handshake, ack and arbitration. The served requester is masked by
  // reusing the ack vector, since ack is exactly its one-hot bit on a fire.
  always_comb begin
    fire_s   = (state_q == ST_GRANT) && out_ready;
    arb_en_s = (state_q == ST_IDLE) || fire_s;
    if (fire_s) begin
      ack_s = {{(N-1){1'b0}}, 1'b1} << src_q;
    end else begin
      ack_s = {N{1'b0}};
    end
    elig_s                   = req & ~ack_s;
    {win_found_s, win_idx_s} = pick(elig_s, ptr_q, mode);
    grant_s                  = arb_en_s && win_found_s;
  end

  // Next-state logic for the FSM and the latched grant registers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (fire_s) begin
          state_d = win_found_s ? ST_GRANT : ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_s) begin
      data_d = req_data[win_idx_s];
      src_d  = win_idx_s;
      // Fixed priority leaves the round-robin pointer untouched.
      ptr_d  = mode ? ptr_q : (win_idx_s + {{(IW-1){1'b0}}, 1'b1});
    end else begin
      data_d = data_q;
      src_d  = src_q;
      ptr_d  = ptr_q;
    end
  end

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {IW{1'b0}};
      data_q  <= {W{1'b0}};
      src_q   <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_GRANT);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign ack       = ack_s;
  assign busy_cnt  = popcount(req);

endmodule
